// File: rtl/w0rm_core_pkg.sv
// Shared definitions for the W0RM core branch unit: condition codes,
// branch addressing modes and the branch history counter reset value.
package w0rm_core_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_VS = 4'd4,
        COND_VC = 4'd5,
        COND_MI = 4'd6,
        COND_PL = 4'd7,
        COND_GE = 4'd8,
        COND_LT = 4'd9,
        COND_GT = 4'd10,
        COND_LE = 4'd11,
        COND_HI = 4'd12,
        COND_LS = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    localparam logic BRANCH_IS_ABSOLUTE = 1'b1;
    localparam logic BRANCH_IS_RELATIVE = 1'b0;

    localparam logic [1:0] BHT_CNT_RESET = 2'b01;

    function automatic logic condTaken(input logic [3:0] code, input logic z,
                                       input logic n, input logic c, input logic v);
        logic taken;
        taken = 1'b0;
        case (cond_e'(code))
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_CS: taken = c;
            COND_CC: taken = !c;
            COND_VS: taken = v;
            COND_VC: taken = !v;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = !z && (n == v);
            COND_LE: taken = z || (n != v);
            COND_HI: taken = c && !z;
            COND_LS: taken = !c || z;
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/w0rm_core_bht.sv
// Branch history table: 2-bit saturating counters with one combinational
// read port and one synchronous update port (read sees the pre-update value).
module w0rm_core_bht
    import w0rm_core_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    logic [1:0] cnt_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= BHT_CNT_RESET;
            end
        end else if (upd_en_i) begin
            if (upd_taken_i && cnt_q[upd_idx_i] != 2'b11) begin
                cnt_q[upd_idx_i] <= cnt_q[upd_idx_i] + 2'b01;
            end else if (!upd_taken_i && cnt_q[upd_idx_i] != 2'b00) begin
                cnt_q[upd_idx_i] <= cnt_q[upd_idx_i] - 2'b01;
            end
        end
    end

    assign rd_taken_o = cnt_q[rd_idx_i][1];

endmodule

// File: rtl/w0rm_core_branch_unit.sv
// Two-stage branch resolution: S1 captures the issued branch and its flags,
// S2 registers the resolved outcome; a flush is raised only on mispredict.
module w0rm_core_branch_unit
    import w0rm_core_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int BHT_DEPTH  = 16,
    parameter int PC_OFFSET  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_ready,
    output logic                  branch_ready,
    input  logic                  data_valid,
    input  logic                  is_branch,
    input  logic                  is_cond_branch,
    input  logic [3:0]            cond_code,
    input  logic                  is_link,
    input  logic                  pred_taken_in,
    input  logic                  alu_flag_zero,
    input  logic                  alu_flag_negative,
    input  logic                  alu_flag_carry,
    input  logic                  alu_flag_overflow,
    input  logic [ADDR_WIDTH-1:0] branch_base_addr,
    input  logic                  branch_rel_abs,
    input  logic [DATA_WIDTH-1:0] rn,
    input  logic [DATA_WIDTH-1:0] lit,
    input  logic [ADDR_WIDTH-1:0] pred_addr,
    output logic                  pred_taken,
    output logic                  branch_valid,
    output logic                  flush_pipeline,
    output logic                  next_pc_valid,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  link_we,
    output logic [DATA_WIDTH-1:0] next_link_reg,
    input  logic [USER_WIDTH-1:0] user_data_in,
    output logic [USER_WIDTH-1:0] user_data_out
);

    localparam int IDX_W  = $clog2(BHT_DEPTH);
    localparam int OFF_SH = $clog2(PC_OFFSET);
    localparam logic [ADDR_WIDTH-1:0] PC_OFF = ADDR_WIDTH'(PC_OFFSET);

    logic                  s1Valid_q, s1Cond_q, s1Link_q, s1Pred_q, s1Abs_q;
    logic [3:0]            s1Code_q;
    logic [3:0]            s1Flags_q;
    logic [ADDR_WIDTH-1:0] s1Base_q, s1Rn_q, s1Lit_q;
    logic [USER_WIDTH-1:0] s1User_q;

    logic                  flush_q, flush_d, bv_q, bv_d, lwe_q, lwe_d;
    logic [ADDR_WIDTH-1:0] npc_q, npc_d;
    logic [DATA_WIDTH-1:0] link_q, link_d;
    logic [USER_WIDTH-1:0] user_q, user_d;

    logic                  accept, resolve, taken, mispredict;
    logic [ADDR_WIDTH-1:0] fallThru, target;
    logic                  unusedAddrBits;

    // A flush in flight kills whatever sits behind it and refuses new issue.
    assign accept  = data_valid && is_branch && !flush_q;
    assign resolve = s1Valid_q && !flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            s1Cond_q  <= 1'b0;
            s1Link_q  <= 1'b0;
            s1Pred_q  <= 1'b0;
            s1Abs_q   <= 1'b0;
            s1Code_q  <= '0;
            s1Flags_q <= '0;
            s1Base_q  <= '0;
            s1Rn_q    <= '0;
            s1Lit_q   <= '0;
            s1User_q  <= '0;
        end else if (mem_ready) begin
            s1Valid_q <= accept;
            if (accept) begin
                s1Cond_q  <= is_cond_branch;
                s1Link_q  <= is_link;
                s1Pred_q  <= pred_taken_in;
                s1Abs_q   <= branch_rel_abs;
                s1Code_q  <= cond_code;
                s1Flags_q <= {alu_flag_zero, alu_flag_negative, alu_flag_carry, alu_flag_overflow};
                s1Base_q  <= branch_base_addr;
                s1Rn_q    <= rn[ADDR_WIDTH-1:0];
                s1Lit_q   <= lit[ADDR_WIDTH-1:0];
                s1User_q  <= user_data_in;
            end
        end
    end

    assign taken = !s1Cond_q || condTaken(s1Code_q, s1Flags_q[3], s1Flags_q[2],
                                          s1Flags_q[1], s1Flags_q[0]);
    assign mispredict = taken != s1Pred_q;
    assign fallThru   = s1Base_q + PC_OFF;
    assign target     = (s1Abs_q == BRANCH_IS_ABSOLUTE) ? s1Rn_q : s1Base_q + s1Lit_q + PC_OFF;

    // While stalled the data fields keep their value but pulses drop to zero.
    always_comb begin
        flush_d = 1'b0;
        bv_d    = 1'b0;
        lwe_d   = 1'b0;
        npc_d   = npc_q;
        link_d  = link_q;
        user_d  = user_q;
        if (mem_ready) begin
            flush_d = resolve && mispredict;
            bv_d    = resolve && taken;
            lwe_d   = resolve && taken && s1Link_q;
            npc_d   = (resolve && mispredict) ? (taken ? target : fallThru) : '0;
            link_d  = (resolve && taken && s1Link_q) ? DATA_WIDTH'(fallThru) : '0;
            user_d  = (resolve && taken) ? s1User_q : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_q <= 1'b0;
            bv_q    <= 1'b0;
            lwe_q   <= 1'b0;
            npc_q   <= '0;
            link_q  <= '0;
            user_q  <= '0;
        end else begin
            flush_q <= flush_d;
            bv_q    <= bv_d;
            lwe_q   <= lwe_d;
            npc_q   <= npc_d;
            link_q  <= link_d;
            user_q  <= user_d;
        end
    end

    w0rm_core_bht #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_idx_i    (pred_addr[OFF_SH +: IDX_W]),
        .rd_taken_o  (pred_taken),
        .upd_en_i    (mem_ready && resolve && s1Cond_q),
        .upd_idx_i   (s1Base_q[OFF_SH +: IDX_W]),
        .upd_taken_i (taken)
    );

    assign unusedAddrBits = ^{pred_addr, rn, lit};

    assign branch_ready   = mem_ready;
    assign flush_pipeline = flush_q;
    assign next_pc_valid  = flush_q;
    assign branch_valid   = bv_q;
    assign link_we        = lwe_q;
    assign next_pc        = npc_q;
    assign next_link_reg  = link_q;
    assign user_data_out  = user_q;

endmodule

// File: tb/tb_w0rm_core_branch_unit.sv
// Scoreboard bench for w0rm_core_branch_unit: directed branches push their
// hand-computed outcome, a negedge monitor pops it when the DUT pulses.
module tb_w0rm_core_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_ready, branch_ready;
    logic        data_valid, is_branch, is_cond_branch, is_link, pred_taken_in;
    logic [3:0]  cond_code;
    logic        alu_flag_zero, alu_flag_negative, alu_flag_carry, alu_flag_overflow;
    logic [31:0] branch_base_addr, rn, lit, pred_addr, next_pc, next_link_reg;
    logic        branch_rel_abs, pred_taken, branch_valid, flush_pipeline, next_pc_valid, link_we;
    logic [0:0]  user_data_in, user_data_out;

    typedef struct {
        int          due;
        logic        flush;
        logic [31:0] npc;
        logic        bv;
        logic        lwe;
        logic [31:0] link;
        logic        user;
    } exp_t;

    exp_t sb[$];
    exp_t monExp;
    int   vecCount = 0;
    int   misCount = 0;
    int   cycleCnt = 0;

    w0rm_core_branch_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mem_ready         (mem_ready),
        .branch_ready      (branch_ready),
        .data_valid        (data_valid),
        .is_branch         (is_branch),
        .is_cond_branch    (is_cond_branch),
        .cond_code         (cond_code),
        .is_link           (is_link),
        .pred_taken_in     (pred_taken_in),
        .alu_flag_zero     (alu_flag_zero),
        .alu_flag_negative (alu_flag_negative),
        .alu_flag_carry    (alu_flag_carry),
        .alu_flag_overflow (alu_flag_overflow),
        .branch_base_addr  (branch_base_addr),
        .branch_rel_abs    (branch_rel_abs),
        .rn                (rn),
        .lit               (lit),
        .pred_addr         (pred_addr),
        .pred_taken        (pred_taken),
        .branch_valid      (branch_valid),
        .flush_pipeline    (flush_pipeline),
        .next_pc_valid     (next_pc_valid),
        .next_pc           (next_pc),
        .link_we           (link_we),
        .next_link_reg     (next_link_reg),
        .user_data_in      (user_data_in),
        .user_data_out     (user_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    function automatic void checkOutput(input string name, input logic [63:0] act,
                                        input logic [63:0] exp);
        vecCount++;
        if (act !== exp) begin
            misCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCnt);
        end
    endfunction

    task automatic expectResult(input int due, input logic fl, input logic [31:0] npc,
                                input logic bv, input logic lwe, input logic [31:0] lnk,
                                input logic usr);
        exp_t e;
        e.due = due; e.flush = fl; e.npc = npc; e.bv = bv;
        e.lwe = lwe; e.link = lnk; e.user = usr;
        sb.push_back(e);
    endtask

    // Presents one branch for a single cycle; flags packed as {Z,N,C,V}.
    task automatic applyStimulus(input logic cond, input logic [3:0] code, input logic lnk,
                                 input logic pred, input logic [3:0] zncv,
                                 input logic [31:0] base, input logic abs,
                                 input logic [31:0] rnv, input logic [31:0] litv,
                                 input logic usr);
        data_valid        = 1'b1;
        is_branch         = 1'b1;
        is_cond_branch    = cond;
        cond_code         = code;
        is_link           = lnk;
        pred_taken_in     = pred;
        {alu_flag_zero, alu_flag_negative, alu_flag_carry, alu_flag_overflow} = zncv;
        branch_base_addr  = base;
        branch_rel_abs    = abs;
        rn                = rnv;
        lit               = litv;
        user_data_in      = usr;
        @(posedge clk); #1;
        data_valid        = 1'b0;
        is_branch         = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic probeBht(input string name, input logic [31:0] addr, input logic exp);
        pred_addr = addr;
        @(negedge clk);
        checkOutput(name, pred_taken, exp);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && (flush_pipeline || next_pc_valid || branch_valid || link_we)) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_pulse", {flush_pipeline, branch_valid, link_we}, 3'b000);
            end else begin
                monExp = sb.pop_front();
                checkOutput("due_cycle",     cycleCnt,       monExp.due);
                checkOutput("flush",         flush_pipeline, monExp.flush);
                checkOutput("next_pc_valid", next_pc_valid,  monExp.flush);
                checkOutput("next_pc",       next_pc,        monExp.npc);
                checkOutput("branch_valid",  branch_valid,   monExp.bv);
                checkOutput("link_we",       link_we,        monExp.lwe);
                checkOutput("next_link_reg", next_link_reg,  monExp.link);
                checkOutput("user_data_out", user_data_out,  monExp.user);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; data_valid = 1'b0; is_branch = 1'b0;
        is_cond_branch = 1'b0; cond_code = '0; is_link = 1'b0; pred_taken_in = 1'b0;
        {alu_flag_zero, alu_flag_negative, alu_flag_carry, alu_flag_overflow} = '0;
        branch_base_addr = '0; branch_rel_abs = 1'b0; rn = '0; lit = '0;
        pred_addr = 32'h100; user_data_in = '0;
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_flush",     flush_pipeline, 1'b0);
        checkOutput("rst_npc_valid", next_pc_valid,  1'b0);
        checkOutput("rst_bv",        branch_valid,   1'b0);
        checkOutput("rst_link_we",   link_we,        1'b0);
        checkOutput("rst_next_pc",   next_pc,        32'h0);
        checkOutput("rst_link",      next_link_reg,  32'h0);
        checkOutput("rst_pred",      pred_taken,     1'b0);
        checkOutput("branch_ready",  branch_ready,   1'b1);
        @(posedge clk); #1;

        // Unconditional relative branch with a "never" code must still be taken.
        expectResult(cycleCnt + 2, 1'b1, 32'h122, 1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 4'd15, 1'b0, 1'b0, 4'b0000, 32'h100, 1'b0, 32'h0, 32'h20, 1'b1);
        idle(3);

        // GT taken and predicted taken: no flush, counter 1 -> 2.
        expectResult(cycleCnt + 2, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 4'd10, 1'b0, 1'b1, 4'b0101, 32'h100, 1'b0, 32'h0, 32'h40, 1'b0);
        idle(3);
        probeBht("bht_inc", 32'h100, 1'b1);

        // EQ not taken while predicted taken: fall-through flush, counter 2 -> 1.
        expectResult(cycleCnt + 2, 1'b1, 32'h202, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b1, 4'b0000, 32'h200, 1'b0, 32'h0, 32'h80, 1'b1);
        idle(3);
        probeBht("bht_dec", 32'h100, 1'b0);

        expectResult(cycleCnt + 2, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 4'd14, 1'b0, 1'b0, 4'b0000, 32'hFFFF_FFFE, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(3);

        expectResult(cycleCnt + 2, 1'b1, 32'h4000, 1'b1, 1'b1, 32'h302, 1'b1);
        applyStimulus(1'b0, 4'd14, 1'b1, 1'b0, 4'b0000, 32'h300, 1'b1, 32'h4000, 32'h55, 1'b1);
        idle(3);

        expectResult(cycleCnt + 2, 1'b1, 32'h412, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 4'd9, 1'b0, 1'b0, 4'b0100, 32'h400, 1'b0, 32'h0, 32'h10, 1'b0);
        idle(3);
        // HI with Z set: not taken and correctly predicted, so nothing is presented.
        applyStimulus(1'b1, 4'd12, 1'b0, 1'b0, 4'b1010, 32'h410, 1'b0, 32'h0, 32'h10, 1'b0);
        idle(3);
        expectResult(cycleCnt + 2, 1'b1, 32'h422, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 4'd11, 1'b0, 1'b1, 4'b0000, 32'h420, 1'b0, 32'h0, 32'h10, 1'b0);
        idle(3);

        // Two branches in the flush shadow must be dropped without output.
        expectResult(cycleCnt + 2, 1'b1, 32'h60A, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 4'd14, 1'b0, 1'b0, 4'b0000, 32'h600, 1'b0, 32'h0, 32'h8, 1'b0);
        applyStimulus(1'b0, 4'd14, 1'b1, 1'b0, 4'b0000, 32'h700, 1'b0, 32'h0, 32'h8, 1'b1);
        applyStimulus(1'b0, 4'd14, 1'b1, 1'b0, 4'b0000, 32'h800, 1'b0, 32'h0, 32'h8, 1'b1);
        idle(4);

        // Stall for three cycles with the branch sitting in S1.
        expectResult(cycleCnt + 5, 1'b1, 32'h116, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 4'd14, 1'b0, 1'b0, 4'b0000, 32'h104, 1'b0, 32'h0, 32'h10, 1'b0);
        mem_ready = 1'b0;
        pred_addr = 32'h104;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall_bht_frozen", pred_taken, 1'b0);
            checkOutput("stall_ready", branch_ready, 1'b0);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("post_stall_bht", pred_taken, 1'b1);
        @(posedge clk); #1;
        idle(3);

        // Reset while a would-be flushing branch is in S1.
        applyStimulus(1'b1, 4'd14, 1'b1, 1'b0, 4'b0000, 32'h108, 1'b0, 32'h0, 32'h10, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        for (int i = 0; i < 16; i++) begin
            probeBht("reset_bht", 32'(i) << 1, 1'b0);
        end

        idle(3);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, misCount);
        $finish;
    end

endmodule

// File: doc/w0rm_core_branch_unit.md
Name: w0rm_core_branch_unit

Overview:
- Next-generation branch resolution unit for the W0RM core, in the execute stage between decode/ALU flags and fetch.
- Resolves conditional and unconditional branches, including signed and unsigned compound conditions, and produces the link value.
- Holds a parametrised branch history table (BHT) of 2-bit saturating counters that fetch reads for prediction.
- Requests a pipeline flush only on a misprediction, not on every taken branch.

Parameters:
- ADDR_WIDTH, 32, PC/target width.
- DATA_WIDTH, 32, register/literal width (must be >= ADDR_WIDTH).
- USER_WIDTH, 1, sideband width carried alongside each branch.
- BHT_DEPTH, 16, number of BHT counters (power of 2, >= 2).
- PC_OFFSET, 2, byte offset added to the base address for the relative target, fall-through and link.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous assert, active-low
- mem_ready  in  1  downstream ready; low stalls the unit
- branch_ready  out  1  equals mem_ready
- data_valid  in  1  issue slot valid
- is_branch  in  1  instruction is a branch
- is_cond_branch  in  1  branch is conditional
- cond_code  in  4  condition select (see Behaviour)
- is_link  in  1  write link register if the branch is taken
- pred_taken_in  in  1  prediction fetch used for this branch
- alu_flag_zero/negative/carry/overflow  in  1 each  flags Z N C V
- branch_base_addr  in  ADDR_WIDTH  PC of the branch
- branch_rel_abs  in  1  1 = absolute (rn), 0 = relative
- rn, lit  in  DATA_WIDTH  register operand, literal
- pred_addr  in  ADDR_WIDTH  fetch PC for the BHT lookup
- pred_taken  out  1  combinational BHT lookup result
- branch_valid  out  1  taken branch retired (pulse)
- flush_pipeline  out  1  misprediction (pulse)
- next_pc_valid  out  1  equals flush_pipeline
- next_pc  out  ADDR_WIDTH  corrected PC
- link_we  out  1  link write strobe (pulse)
- next_link_reg  out  DATA_WIDTH  link value
- user_data_in / user_data_out  USER_WIDTH  sideband in / out

Behaviour:
- Reset: all outputs 0, pipeline registers 0, every BHT counter 2'b01 (weakly not-taken). Reset asserted mid-operation discards any in-flight branch.
- Pipeline stage S1 captures the branch when data_valid & is_branch & mem_ready.
- Pipeline stage S2 registers the resolved result. Outputs are valid 2 cycles after acceptance.
- When mem_ready = 0, S1 and S2 hold and output pulses do not repeat.
- Condition codes:
  - 0 Z, 1 !Z, 2 C, 3 !C, 4 V, 5 !V, 6 N, 7 !N
  - 8 N==V (GE), 9 N!=V (LT), 10 !Z&(N==V) (GT), 11 Z|(N!=V) (LE)
  - 12 C&!Z (HI), 13 !C|Z (LS), 14 always, 15 never
  - Unconditional branches (is_cond_branch = 0) are always taken.
- Flags are sampled at S1 capture.
- Relative target = (base + lit[ADDR_WIDTH-1:0] + PC_OFFSET) mod 2^ADDR_WIDTH, wrapping silently. Absolute target = rn[ADDR_WIDTH-1:0].
- Mispredict = taken != pred_taken_in. On mispredict:
  - if taken, next_pc = target;
  - if not taken, next_pc = base + PC_OFFSET;
  - flush_pipeline = next_pc_valid = 1 for one cycle.
  - Otherwise next_pc = 0.
- Flush clears S1 and blocks acceptance in that cycle; a branch presented then is dropped. Issue must squash it.
- branch_valid = 1 for one cycle per taken branch.
- link_we = 1 for one cycle on a taken branch with is_link = 1; next_link_reg = zero-extended base + PC_OFFSET. Otherwise next_link_reg = 0.
- user_data_out = the captured sideband when taken, else 0.
- BHT index = addr[log2(BHT_DEPTH)+0 +: log2(BHT_DEPTH)] after dropping the low log2(PC_OFFSET) bits.
- pred_taken = counter[1].
- Counter update at S2 resolve, conditional branches only, saturating at 0 and 3, gated by mem_ready.
- Read and update of the same index in the same cycle: the read returns the old value.

Decomposition:
- Package w0rm_core_pkg holds the COND_* codes (4-bit), BRANCH_IS_ABSOLUTE/RELATIVE, and the BHT counter reset constant.
- Sub-module w0rm_core_bht: the counter array with one combinational read port and one synchronous saturating update port.

Test Plan:
- Unconditional relative branch, base 0x100, lit 0x20, pred 0 → 2 cycles later flush = 1, next_pc = 0x122, branch_valid = 1.
- cond 10 (GT) with Z=0 N=1 V=1, pred 1 → no flush, branch_valid = 1; the BHT entry at 0x100 increments from 1 to 2, so pred_taken(0x100) = 1.
- cond 0 with Z=0, pred 1, base 0x200 → flush, next_pc = 0x202, branch_valid = 0, counter decrements.
- Relative wrap: base 0xFFFF_FFFE, lit 0, taken → next_pc = 0x0000_0000. Absolute with is_link: rn 0x4000, base 0x300 → next_pc = 0x4000, link_we = 1, next_link_reg = 0x302.
- Hold mem_ready = 0 for 3 cycles mid-flight → outputs and BHT frozen; a single pulse after release.
- rst_n asserted between S1 and S2 → no flush or pulses; all counters read 1.
